// File: rtl/display_pkg.sv
// Shared constants, types and digit patterns for the multiplexed 7-segment driver.
// All segment/anode values are active-low (common-anode display).
package display_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  typedef logic [7:0][3:0] bcd8_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      default: seg_pattern = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Converter-side inputs and display pins of the BCD display driver.
interface bcd_display_driver_if;
  import display_pkg::*;

  logic       idle;
  bcd8_t      bcd;
  logic       lz_en;
  logic       blank;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp_n;

  modport master (output idle, bcd, lz_en, blank, input an, seg, dp_n);
  modport slave  (input idle, bcd, lz_en, blank, output an, seg, dp_n);
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder; invalid nibbles show a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = (nib > 4'd9) ? SEG_DASH : seg_pattern(nib);

endmodule

// File: rtl/bcd_display_driver.sv
// Captures the converter result on idle rising, then scans 8 digits one at a time
// with optional leading-zero blanking and a global blank.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_display_driver_if.slave  dsp
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic          idle_q, idle_d;
  bcd8_t         shown_q, shown_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          lz_run;
  logic [7:0]    dig_blank;
  logic [6:0]    dec_seg;

  bcd_to_7seg u_dec (
    .nib   (shown_q[digit_idx_q]),
    .seg_n (dec_seg)
  );

  // Walk from the top digit down; a digit is blanked while only zeros sit above and at it.
  always_comb begin
    lz_run    = 1'b1;
    dig_blank = '0;
    for (int k = 7; k >= 1; k--) begin
      lz_run       = lz_run && (shown_q[k] == 4'd0);
      dig_blank[k] = dsp.lz_en && lz_run;
    end
  end

  always_comb begin
    idle_d      = dsp.idle;
    shown_d     = (dsp.idle && !idle_q) ? dsp.bcd : shown_q;
    tick        = (div_cnt_q == DIV_LAST);
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    an_d        = ~(8'd1 << digit_idx_q);
    seg_d       = dig_blank[digit_idx_q] ? SEG_OFF : dec_seg;
    if (dsp.blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q      <= 1'b1;
      shown_q     <= '0;
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      idle_q      <= idle_d;
      shown_q     <= shown_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign dsp.an   = an_q;
  assign dsp.seg  = seg_q;
  assign dsp.dp_n = 1'b1;

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Consumes the packed 8-digit BCD result of the binary-to-BCD converter and drives an 8-digit, common-anode, time-multiplexed 7-segment display. It captures a new value only when the converter finishes a conversion (rising edge of its `idle`), so the display never shows a half-converted value. It scans one digit at a time at a programmable rate and optionally blanks leading zeros. It sits directly downstream of the converter and drives the board pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit; legal range 2..2^20.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `idle`  in  1  converter idle flag; a 0→1 transition means `bcd` is valid.
- `bcd`  in  32  packed BCD; digit k = `bcd[4k+3:4k]`, where k=0 is the least significant digit.
- `lz_en`  in  1  leading-zero blanking enable.
- `blank`  in  1  forces the whole display dark.
- `an`  out  8  digit enables, active-low; `an[k]` drives digit k.
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp_n`  out  1  decimal point, active-low; held at 1.

## Operation
- **Capture**
  - Register `idle_q` follows `idle` every cycle; it resets to 1.
  - When `idle && !idle_q`, register `shown` ← `bcd`; `shown` resets to 0.
  - Between captures, `shown` holds; changes on `bcd` have no effect.
- **Prescaler**
  - Counter `div_cnt` runs 0..SCAN_DIV-1 and wraps.
  - `tick` = (`div_cnt` == SCAN_DIV-1).
- **Scan index**
  - 3-bit `digit_idx` increments on `tick`, wrapping from 7 to 0. Scan order is 0,1,…,7,0.
- **Blanking**
  - Digit k (k ≥ 1) is blanked when `lz_en`=1 and digits 7..k of `shown` are all zero.
  - Digit 0 is never blanked by `lz_en`, so a value of 0 shows a single "0".
- **Decode**
  - Nibbles 0–9 use the standard patterns: 0 → `seg`=7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000.
  - Nibbles 10–15 (invalid BCD) show a dash: `seg`=7'b0111111.
- **Output registers**, updated every cycle:
  - If `blank`=1: `an` ← 8'hFF, `seg` ← 7'h7F.
  - Else if the current digit is blanked: `an` ← one-hot-low of `digit_idx`, `seg` ← 7'h7F.
  - Else: `an` ← one-hot-low of `digit_idx`, `seg` ← decode(`shown` digit `digit_idx`).
- **Reset values:** `an`=8'hFF, `seg`=7'h7F, `dp_n`=1, `digit_idx`=0, `div_cnt`=0, `shown`=0, `idle_q`=1.

## Timing
- `an` and `seg` are registered and reflect `digit_idx`/`shown` with 1 cycle of latency.
- Each digit's enable stays low for exactly SCAN_DIV consecutive cycles. The full frame is 8·SCAN_DIV cycles.
- At most one bit of `an` is low in any cycle.
- Capture latency: `idle` rises before edge e → `shown` updates at edge e → new digits reach the pins at edge e+1.
- **Simultaneous capture and `tick`:** the new digit index uses the new `shown` value one cycle later. No glitch pattern is ever emitted.
- **`blank`** acts with 1 cycle of latency and does not stop `div_cnt` or `digit_idx`.
- **`idle` held at 1 through reset release:** no capture, because `idle_q` resets to 1.
- **Reset mid-scan:** all registers return to their reset values immediately, asynchronously. Scanning restarts at digit 0 with a full SCAN_DIV dwell.

## Structure
- Shared package `display_pkg` holds:
  - `SEG_OFF` (7'h7F), `SEG_DASH`, `AN_OFF` (8'hFF);
  - a function or constant array for the digit patterns 0–9;
  - typedef `bcd8_t` (32-bit packed, 8 × 4-bit digits).
- One sub-module: `bcd_to_7seg`, a combinational 4-bit nibble in → 7-bit active-low segments out, including the dash rule.
- The top level holds the capture logic, prescaler, scan counter, leading-zero logic and output registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame → `an`=8'hFF, `seg`=7'h7F, `dp_n`=1 with no clock edge. Release → digit 0 enabled first and held 4 cycles (SCAN_DIV=4).
- **Scan:** SCAN_DIV=4, `shown`=32'h87654321 → `an` steps FE, FD, FB, … 7F, FE every 4 cycles. `seg` shows 1..8 in order; never two anodes low.
- **Capture:** pulse `idle` 0→1 with `bcd`=32'h00012345, `lz_en`=1 → digits 7..5 dark (`seg`=7F while enabled), digits 4..0 show 1,2,3,4,5. Changing `bcd` afterwards without an `idle` edge → display unchanged.
- **Zero and invalid digits:** `bcd`=0, `lz_en`=1 → only digit 0 lit, showing "0". `bcd`=32'h0000000A, `lz_en`=0 → digit 0 shows a dash and digits 1–7 show "0".
- **Blank:** `blank`=1 for 10 cycles → `an`=8'hFF throughout. Release → scanning resumes at the index the counter has reached, not at digit 0.
- **Simultaneous events:** `idle` edge in the same cycle as `tick` → the next digit shows the newly captured value, verified against a reference model every cycle.
